// File: rtl/imm_split_32_16.sv
// Purpose : turns a 32-bit constant + destination register into the LUI/ORI (or single ORI/ADDIU/LUI) sequence that rebuilds it.
// Latency : request accepted at edge N -> first instruction valid after edge N; LUI/ORI pair spans two cycles with instr_ready high.
// Backpr. : instr/instr_last hold while instr_valid && !instr_ready; req_ready is low for the whole sequence.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_ready            constant request handshake
//   req_value[31:0], req_rt[4:0]   constant and destination register
//   instr_valid/instr_ready        instruction handshake toward the memory writer
//   instr[31:0], instr_last        registered instruction word, final-word marker
//
// Build option: define SHORT_FORM_EN to emit single-instruction forms
// (ORI / ADDIU / LUI) where one instruction suffices. Without it every
// constant, including zero, is emitted as LUI then ORI.
module imm_split_32_16 #(
    parameter logic [5:0] OP_LUI   = 6'b001111,
    parameter logic [5:0] OP_ORI   = 6'b001101,
    parameter logic [5:0] OP_ADDIU = 6'b001001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_value,
    input  logic [4:0]  req_rt,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic        instr_last
);

`ifdef SHORT_FORM_EN
    localparam bit SHORT_EN = 1'b1;
`else
    localparam bit SHORT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMIT_HI = 2'd1,
        EMIT_LO = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [4:0]  rt_q, rt_nxt;
    logic [15:0] lo_q, lo_nxt;
    logic [31:0] instr_nxt;
    logic        valid_nxt;
    logic        last_nxt;

    // Decode of the incoming constant for the single-instruction forms.
    logic hi_zero;
    logic sext_ok;
    logic lo_zero;

    assign hi_zero = (req_value[31:16] == 16'h0000);
    // Upper 17 bits all ones: ADDIU's sign extension of value[15:0] rebuilds it.
    assign sext_ok = &req_value[31:15];
    assign lo_zero = (req_value[15:0] == 16'h0000);

    assign req_ready = (state == IDLE);

    always_comb begin
        state_nxt = state;
        rt_nxt    = rt_q;
        lo_nxt    = lo_q;
        instr_nxt = instr;
        valid_nxt = instr_valid;
        last_nxt  = instr_last;

        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    rt_nxt    = req_rt;
                    lo_nxt    = req_value[15:0];
                    valid_nxt = 1'b1;
                    if (SHORT_EN && hi_zero) begin
                        instr_nxt = {OP_ORI, 5'd0, req_rt, req_value[15:0]};
                        last_nxt  = 1'b1;
                        state_nxt = EMIT_LO;
                    end else if (SHORT_EN && sext_ok) begin
                        instr_nxt = {OP_ADDIU, 5'd0, req_rt, req_value[15:0]};
                        last_nxt  = 1'b1;
                        state_nxt = EMIT_LO;
                    end else if (SHORT_EN && lo_zero) begin
                        instr_nxt = {OP_LUI, 5'd0, req_rt, req_value[31:16]};
                        last_nxt  = 1'b1;
                        state_nxt = EMIT_LO;
                    end else begin
                        instr_nxt = {OP_LUI, 5'd0, req_rt, req_value[31:16]};
                        last_nxt  = 1'b0;
                        state_nxt = EMIT_HI;
                    end
                end
            end
            EMIT_HI: begin
                if (instr_ready) begin
                    // ORI reads back the register LUI just wrote (rs = rt).
                    instr_nxt = {OP_ORI, rt_q, rt_q, lo_q};
                    last_nxt  = 1'b1;
                    state_nxt = EMIT_LO;
                end
            end
            EMIT_LO: begin
                if (instr_ready) begin
                    valid_nxt = 1'b0;
                    last_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rt_q        <= 5'd0;
            lo_q        <= 16'h0000;
            instr       <= 32'h0000_0000;
            instr_valid <= 1'b0;
            instr_last  <= 1'b0;
        end else begin
            state       <= state_nxt;
            rt_q        <= rt_nxt;
            lo_q        <= lo_nxt;
            instr       <= instr_nxt;
            instr_valid <= valid_nxt;
            instr_last  <= last_nxt;
        end
    end

endmodule

// File: tb/tb_imm_split_32_16.sv
module tb_imm_split_32_16;

    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_value;
    logic [4:0]  req_rt;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        instr_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_split_32_16 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_value   (req_value),
        .req_rt      (req_rt),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_last  (instr_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [31:0] imm);
        logic [4:0]  rs5;
        logic [4:0]  rt5;
        logic [15:0] imm16;
        rs5   = rs[4:0];
        rt5   = rt[4:0];
        imm16 = imm[15:0];
        return {op, rs5, rt5, imm16};
    endfunction

    // Reference: what instruction list reproduces v in register rt at decode.
    task automatic model(input logic [31:0] v, input logic [4:0] rt, output int n,
                         output logic [31:0] e0, output logic [31:0] e1);
        int r;
        r  = int'(rt);
        n  = 2;
        e0 = itype(OP_LUI, 0, r, v / 32'd65536);
        e1 = itype(OP_ORI, r, r, v % 32'd65536);
`ifdef SHORT_FORM_EN
        if (v < 32'd65536) begin
            n  = 1;
            e0 = itype(OP_ORI, 0, r, v);
        end else if (v >= 32'hFFFF_8000) begin
            n  = 1;
            e0 = itype(OP_ADDIU, 0, r, v % 32'd65536);
        end else if (v % 32'd65536 == 0) begin
            n  = 1;
            e0 = itype(OP_LUI, 0, r, v / 32'd65536);
        end
`endif
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int cnt;
        cnt = 0;
        while (!req_ready && cnt < 20) begin
            step();
            cnt++;
        end
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    // One request; the first word is held off for 'stall' cycles while a
    // competing request is presented and must not be accepted.
    task automatic run_seq(input string tag, input logic [31:0] v, input logic [4:0] rt,
                           input int n, input logic [31:0] e0, input logic [31:0] e1, input int stall);
        logic [31:0] w;
        wait_ready(tag);
        req_valid   = 1'b1;
        req_value   = v;
        req_rt      = rt;
        instr_ready = (stall == 0);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            w = (i == 0) ? e0 : e1;
            if (i == 0) begin
                for (int s = 0; s < stall; s++) begin
                    req_valid = 1'b1;
                    req_value = ~v;
                    chk({tag, "_stall_instr"}, instr, w);
                    chk({tag, "_stall_valid"}, {31'd0, instr_valid}, 32'd1);
                    chk({tag, "_stall_req_ready"}, {31'd0, req_ready}, 32'd0);
                    step();
                end
                req_valid   = 1'b0;
                instr_ready = 1'b1;
            end
            chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
            chk({tag, "_instr"}, instr, w);
            chk({tag, "_last"}, {31'd0, instr_last}, (i == n - 1) ? 32'd1 : 32'd0);
            chk({tag, "_busy"}, {31'd0, req_ready}, 32'd0);
            step();
        end
        chk({tag, "_end_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_end_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int          n;
        int          n2;
        logic [31:0] e0, e1, f0, f1, v, r;
        logic [4:0]  rt;
        logic [31:0] sw[6];
        logic        sv[6];
        logic        sl[6];
        int          len;

        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_value   = 32'h0;
        req_rt      = 5'd0;
        instr_ready = 1'b1;
        #12;
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_last", {31'd0, instr_last}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        rst_n = 1'b1;
        step();

        // Directed test-plan vectors.
        run_seq("pair", 32'h1234_5678, 5'd8, 2, 32'h3C08_1234, 32'h3508_5678, 0);
`ifdef SHORT_FORM_EN
        run_seq("ori", 32'h0000_BEEF, 5'd9, 1, 32'h3409_BEEF, 32'h0, 0);
        run_seq("addiu", 32'hFFFF_8000, 5'd10, 1, 32'h240A_8000, 32'h0, 0);
        run_seq("lui", 32'hABCD_0000, 5'd11, 1, 32'h3C0B_ABCD, 32'h0, 0);
        run_seq("zero", 32'h0, 5'd1, 1, 32'h3401_0000, 32'h0, 0);
`else
        run_seq("beef", 32'h0000_BEEF, 5'd9, 2, 32'h3C09_0000, 32'h3529_BEEF, 0);
        run_seq("zero", 32'h0, 5'd1, 2, 32'h3C01_0000, 32'h3421_0000, 0);
`endif
        run_seq("stall", 32'h1234_5678, 5'd8, 2, 32'h3C08_1234, 32'h3508_5678, 5);
        run_seq("rt0", 32'h8765_4321, 5'd0, 2, 32'h3C00_8765, 32'h3400_4321, 0);

        // Back-to-back with req_valid held: one bubble between sequences.
        model(32'h1234_5678, 5'd8, n, e0, e1);
        model(32'h00C0_FFEE, 5'd3, n2, f0, f1);
        len = 0;
        sw[len] = e0; sv[len] = 1'b1; sl[len] = (n == 1); len++;
        if (n == 2) begin sw[len] = e1; sv[len] = 1'b1; sl[len] = 1'b1; len++; end
        sw[len] = 32'h0; sv[len] = 1'b0; sl[len] = 1'b0; len++;
        sw[len] = f0; sv[len] = 1'b1; sl[len] = (n2 == 1); len++;
        if (n2 == 2) begin sw[len] = f1; sv[len] = 1'b1; sl[len] = 1'b1; len++; end
        wait_ready("b2b");
        req_valid = 1'b1;
        req_value = 32'h1234_5678;
        req_rt    = 5'd8;
        step();
        req_value = 32'h00C0_FFEE;
        req_rt    = 5'd3;
        for (int i = 0; i < len; i++) begin
            chk("b2b_valid", {31'd0, instr_valid}, {31'd0, sv[i]});
            if (sv[i]) begin
                chk("b2b_instr", instr, sw[i]);
                chk("b2b_last", {31'd0, instr_last}, {31'd0, sl[i]});
            end else begin
                chk("b2b_bubble_ready", {31'd0, req_ready}, 32'd1);
            end
            step();
            if (i > 0 && !sv[i - 1] || !sv[i]) req_valid = 1'b0;
        end
        chk("b2b_end_valid", {31'd0, instr_valid}, 32'd0);

        // Asynchronous reset while the final word is stalled.
        wait_ready("arst");
        req_valid   = 1'b1;
        req_value   = 32'h1234_5678;
        req_rt      = 5'd8;
        instr_ready = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        instr_ready = 1'b0;
        chk("arst_pre_instr", instr, 32'h3508_5678);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, instr_valid}, 32'd0);
        chk("arst_instr", instr, 32'h0);
        chk("arst_last", {31'd0, instr_last}, 32'd0);
        chk("arst_req_ready", {31'd0, req_ready}, 32'd1);
        #3;
        rst_n = 1'b1;
        instr_ready = 1'b1;
        step();
        run_seq("post_rst", 32'h1234_5678, 5'd8, 2, 32'h3C08_1234, 32'h3508_5678, 0);

        // Randomized constants biased toward each form, with random stalls.
        for (int k = 0; k < 40; k++) begin
            r = $urandom;
            case ($urandom_range(0, 3))
                0: v = r % 32'd65536;
                1: v = 32'hFFFF_8000 | (r % 32'd32768);
                2: v = r & 32'hFFFF_0000;
                default: v = r;
            endcase
            rt = 5'($urandom_range(0, 31));
            model(v, rt, n, e0, e1);
            run_seq("rand", v, rt, n, e0, e1, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
